// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the dump FSM state encoding and the read-select rule used by every read
// port and by the dump capture path.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Dump engine states: ST_IDLE waits for dbg_start, ST_DUMP streams beats
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } dump_state_e;

    // Source chosen for one read: stored value, hardwired zero, or write data
    typedef enum logic [1:0] {
        SEL_STORE = 2'd0,
        SEL_ZERO  = 2'd1,
        SEL_WDATA = 2'd2
    } rd_sel_e;

    // The hardwired zero register wins over bypass; bypass is suppressed by a
    // same-cycle clear because the clear discards that write.
    function automatic rd_sel_e read_sel(input logic zero_reg,
                                         input logic bypass,
                                         input logic addr_is_zero,
                                         input logic wr_hit,
                                         input logic clear);
        if (zero_reg && addr_is_zero) return SEL_ZERO;
        if (bypass && wr_hit && !clear) return SEL_WDATA;
        return SEL_STORE;
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Debug dump engine: walks registers 0..DEPTH-1, one captured beat per
// accepted transfer, with a valid/ready handshake towards the consumer.
//
// Handshake: a beat transfers on a rising edge where valid_o && ready_i.
// While valid_o is high and ready_i is low, addr_o/data_o/last_o hold.
// valid_o stays high from the cycle after start until the last beat is taken.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] cap_data_i,
    output logic [ADDR_W-1:0] cap_addr_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              done_o,
    output dump_state_e       state_o
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              last;

    assign last    = (state_q == ST_DUMP) && (ptr_q == {ADDR_W{1'b1}});
    assign valid_o = (state_q == ST_DUMP);
    assign addr_o  = ptr_q;
    assign data_o  = data_q;
    assign last_o  = last;
    assign done_o  = done_q;
    assign state_o = state_q;

    // Next state, pointer advance and capture of the next register
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        cap_addr_o = ADDR_W'(ptr_q + 1'b1);
        case (state_q)
            ST_IDLE: begin
                cap_addr_o = '0;
                if (start_i) begin
                    state_d = ST_DUMP;
                    ptr_d   = '0;
                    data_d  = cap_data_i;
                end
            end
            ST_DUMP: begin
                if (ready_i) begin
                    if (last) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                        data_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d  = cap_addr_o;
                        data_d = cap_data_i;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer, captured beat and done pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional hardwired zero
// register, write-to-read bypass, single-cycle clear and a debug dump engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     ctrl_writeEnable,
    input  logic [ADDR_W-1:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0]        data_writeReg,
    input  logic                     ctrl_clear,
    input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    input  logic                     dbg_start,
    input  logic                     dbg_ready,
    output logic                     dbg_valid,
    output logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     dbg_last,
    output logic                     dbg_busy,
    output logic                     dbg_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_ok;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    dump_state_e       dump_state;

    assign wr_ok = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));

    // Storage: clear has priority over a same-cycle write
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (ctrl_clear) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Independent combinational read ports
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        rd_sel_e           sel;
        assign ra  = ctrl_readReg[k*ADDR_W +: ADDR_W];
        assign sel = read_sel(ZERO_REG != 0, BYPASS != 0, ra == '0,
                              ctrl_writeEnable && (ra == ctrl_writeReg), ctrl_clear);
        assign data_readReg[k*DATA_W +: DATA_W] =
            (sel == SEL_ZERO)  ? '0 :
            (sel == SEL_WDATA) ? data_writeReg : regs_q[ra];
    end

    // Capture port: the post-edge content of the register being captured,
    // so a write or clear committing on the capture edge is included
    always_comb begin
        cap_data = regs_q[cap_addr];
        if (ctrl_clear) begin
            cap_data = '0;
        end else begin
            case (read_sel(ZERO_REG != 0, 1'b1, cap_addr == '0,
                           ctrl_writeEnable && (cap_addr == ctrl_writeReg), 1'b0))
                SEL_ZERO:  cap_data = '0;
                SEL_WDATA: cap_data = data_writeReg;
                default:   cap_data = regs_q[cap_addr];
            endcase
        end
    end

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk_i      (clock),
        .rst_ni     (ctrl_reset_n),
        .start_i    (dbg_start),
        .ready_i    (dbg_ready),
        .cap_data_i (cap_data),
        .cap_addr_o (cap_addr),
        .valid_o    (dbg_valid),
        .addr_o     (dbg_addr),
        .data_o     (dbg_data),
        .last_o     (dbg_last),
        .done_o     (dbg_done),
        .state_o    (dump_state)
    );

    assign dbg_busy = (dump_state == ST_DUMP);

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (zero reg, bypass, 2 ports) and a
// second instance with zero reg and bypass off and 3 read ports. Reads and
// the dump stream are checked every cycle against a behavioural model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n;

  // shared write/control inputs
  logic          we, clr, start, ready;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  // instance 0 (ZERO_REG=1, BYPASS=1, NUM_RD=2)
  logic [2*AW-1:0] ra0;
  logic [2*DW-1:0] rd0;
  logic            valid0, last0, busy0, done0;
  logic [AW-1:0]   addr0;
  logic [DW-1:0]   data0;

  // instance 1 (ZERO_REG=0, BYPASS=0, NUM_RD=3), dump never started
  logic [3*AW-1:0] ra1;
  logic [3*DW-1:0] rd1;
  logic            valid1, last1, busy1, done1;
  logic [AW-1:0]   addr1;
  logic [DW-1:0]   data1;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
    .data_writeReg(wdata), .ctrl_clear(clr), .ctrl_readReg(ra0), .data_readReg(rd0),
    .dbg_start(start), .dbg_ready(ready), .dbg_valid(valid0), .dbg_addr(addr0),
    .dbg_data(data0), .dbg_last(last0), .dbg_busy(busy0), .dbg_done(done0)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
    .data_writeReg(wdata), .ctrl_clear(clr), .ctrl_readReg(ra1), .data_readReg(rd1),
    .dbg_start(1'b0), .dbg_ready(1'b1), .dbg_valid(valid1), .dbg_addr(addr1),
    .dbg_data(data1), .dbg_last(last1), .dbg_busy(busy1), .dbg_done(done1)
  );

  // reference model: register contents and dump progress
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];
  bit            mbusy, mdone;
  int            midx;
  logic [DW-1:0] mdata;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp0(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && !clr && a == waddr) return wdata;
    return m0[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    mbusy = 0; mdone = 0; midx = 0; mdata = '0;
  endtask

  // one clock: check reads before the edge, advance the model, check dump after
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) chk("rd0", rd0[k*DW +: DW], exp0(ra0[k*AW +: AW]));
    for (int k = 0; k < 3; k++) chk("rd1", rd1[k*DW +: DW], m1[ra1[k*AW +: AW]]);
    @(posedge clock);
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        m0[i] = '0;
        m1[i] = '0;
      end
    end else if (we) begin
      if (waddr != 0) m0[waddr] = wdata;
      m1[waddr] = wdata;
    end
    mdone = 0;
    if (!mbusy && start) begin
      mbusy = 1; midx = 0; mdata = m0[0];
    end else if (mbusy && ready) begin
      if (midx == DEPTH - 1) begin
        mbusy = 0; mdone = 1; midx = 0;
      end else begin
        midx++;
        mdata = m0[midx];
      end
    end
    #1;
    chk("dbg_valid", valid0, mbusy);
    chk("dbg_busy", busy0, mbusy);
    chk("dbg_done", done0, mdone);
    chk("dbg_last", last0, mbusy && midx == DEPTH - 1);
    if (mbusy) begin
      chk("dbg_addr", addr0, midx);
      chk("dbg_data", data0, mdata);
    end
    chk("idle1", {valid1, last1, busy1, done1, addr1, data1}, '0);
  endtask

  task automatic quiet();
    we = 0; clr = 0; start = 0;
  endtask

  int beats, hold;

  initial begin
    // reset state
    rst_n = 0; quiet(); ready = 0; waddr = '0; wdata = '0; ra0 = '0; ra1 = '0;
    model_reset();
    #12;
    chk("rst_rd0", rd0, '0);
    chk("rst_dbg", {valid0, busy0, done0, last0, addr0, data0}, '0);
    rst_n = 1;

    // 1: basic write/read and r0 hardwired zero
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; ra0 = {5'd5, 5'd5}; ra1 = {5'd5, 5'd5, 5'd5};
    tick();
    quiet();
    chk("t1_r5_p0", rd0[DW-1:0], 32'hDEADBEEF);
    chk("t1_r5_p1", rd0[2*DW-1:DW], 32'hDEADBEEF);
    tick();
    we = 1; waddr = 0; wdata = 32'h1234; ra0 = '0; ra1 = '0;
    tick();
    quiet();
    tick();
    chk("t1_r0_zero", rd0[DW-1:0], 32'h0);
    chk("t1_r0_plain", rd1[DW-1:0], 32'h1234);

    // 2: same-cycle write/read bypass on instance 0, none on instance 1
    we = 1; waddr = 7; wdata = 32'hA5A5A5A5; ra0 = {5'd7, 5'd0}; ra1 = {5'd7, 5'd7, 5'd7};
    #1;
    chk("t2_bypass", rd0[2*DW-1:DW], 32'hA5A5A5A5);
    chk("t2_nobypass", rd1[2*DW-1:DW], 32'h0);
    tick();
    quiet();

    // 3: clear beats a same-cycle write, then every register reads 0
    we = 1; clr = 1; waddr = 3; wdata = 32'h11; ra0 = {5'd3, 5'd3};
    tick();
    quiet();
    chk("t3_r3", rd0[DW-1:0], 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      ra0 = {AW'(i), AW'(DEPTH - 1 - i)}; ra1 = {AW'(i), AW'(i), AW'(i)};
      tick();
    end

    // 4: load r[i]=i*3 and dump with ready held high
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; waddr = AW'(i); wdata = DW'(i * 3); ra0 = AW'($urandom_range(0, DEPTH - 1)) * 2'd1;
      tick();
    end
    quiet(); ready = 1; start = 1;
    tick();
    start = 0; beats = 0;
    for (int c = 0; c < 100 && busy0; c++) begin
      if (valid0) beats++;
      tick();
    end
    chk("t4_beats", beats, DEPTH);
    chk("t4_ended", busy0, 1'b0);

    // 5: back-pressure at beat 10 with a write, mid-dump write to r20
    start = 1; ready = 1;
    tick();
    hold = 0;
    for (int c = 0; c < 200 && mbusy; c++) begin
      quiet(); ready = 1;
      if (midx == 5) start = 1;
      if (midx == 10 && hold < 4) begin
        ready = 0; hold++;
        if (hold == 2) begin we = 1; waddr = 10; wdata = 32'hFF; end
      end
      if (midx == 15) begin we = 1; waddr = 20; wdata = 32'h77; end
      tick();
      if (midx == 10 && !ready) begin
        chk("t5_hold_addr", addr0, 10);
        chk("t5_hold_data", data0, 30);
      end
      if (midx == 20 && mbusy) chk("t5_beat20", data0, 32'h77);
    end
    quiet();
    chk("t5_timeout", busy0, 1'b0);
    tick();

    // 6: reset in the middle of a dump, then a fresh dump from address 0
    start = 1; ready = 1;
    tick();
    start = 0;
    for (int c = 0; c < 50 && midx != 12; c++) tick();
    chk("t6_at12", addr0, 12);
    rst_n = 0;
    model_reset();
    #1;
    chk("t6_rst_vb", {valid0, busy0, done0, last0}, '0);
    chk("t6_rst_regs", rd0, '0);
    #2;
    rst_n = 1;
    for (int c = 0; c < 3; c++) tick();
    start = 1;
    tick();
    start = 0;
    chk("t6_restart_addr", addr0, 0);
    for (int c = 0; c < 100 && mbusy; c++) tick();
    chk("t6_timeout", busy0, 1'b0);

    // 7: randomized traffic: writes, clears, reads, dumps and back-pressure
    for (int c = 0; c < 400; c++) begin
      we    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 19) == 0);
      ready = ($urandom_range(0, 3) != 0);
      waddr = AW'($urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      ra0   = {AW'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1))};
      ra1   = {AW'($urandom_range(0, DEPTH - 1)), waddr, AW'($urandom_range(0, DEPTH - 1))};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
